// File: rtl/minesweeper_pkg.sv
// Shared board geometry, cell word layout and writer FSM states for the minesweeper core.
package minesweeper_pkg;

    localparam int BOARD_DIM = 8;
    localparam int CELL_W    = 9;
    localparam int MINE_BIT  = 0;
    localparam int CNT_LSB   = 1;
    localparam int CNT_W     = 4;

    // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef struct packed {
        logic [3:0]       flags;
        logic [CNT_W-1:0] count;
        logic             mine;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/mine_lfsr.sv
// Galois LFSR used to pick mine candidates; a zero load value is replaced by the default seed.
module mine_lfsr #(
    parameter int             W            = 8,
    parameter logic [W-1:0]   TAPS         = 8'hB8,
    parameter logic [W-1:0]   DEFAULT_SEED = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         en,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= DEFAULT_SEED;
        end else if (load) begin
            value <= (seed == '0) ? DEFAULT_SEED : seed;
        end else if (en) begin
            value <= value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
        end
    end

endmodule

// File: rtl/mine_board_writer.sv
// Places mines pseudo-randomly into a 64-bit bitmap, then streams every cell word
// (mine bit plus neighbour count) to the board matrix, one cell per cycle.
module mine_board_writer #(
    parameter int               CELL_W       = 9,
    parameter int               LFSR_W       = 8,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic [6:0]        mine_count,
    input  logic              safe_en,
    input  logic [3:0]        safe_x,
    input  logic [3:0]        safe_y,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [3:0]        wr_x,
    output logic [3:0]        wr_y,
    output logic [CELL_W-1:0] wr_data,
    output logic [6:0]        mines_placed
);
    import minesweeper_pkg::*;

    fsm_state_t        state_reg, state_next;
    logic [63:0]       bitmap_reg;
    logic [6:0]        target_reg;
    logic              safe_en_reg;
    logic [5:0]        safe_idx_reg;
    logic [5:0]        idx_reg;
    logic [LFSR_W-1:0] lfsr_value;
    logic [5:0]        cand;
    logic              accept;
    logic              place_hit;
    logic [6:0]        target_next;
    cell_t             cell_next;

    function automatic logic [CNT_W-1:0] neighbour_count(input logic [63:0] map,
                                                         input logic [5:0]  idx);
        logic [CNT_W-1:0] n;
        logic [5:0]       nidx;
        int               x, y, nx, ny;
        n = '0;
        x = int'(idx[2:0]);
        y = int'(idx[5:3]);
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = x + dx;
                ny = y + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < BOARD_DIM &&
                    ny >= 0 && ny < BOARD_DIM) begin
                    nidx = 6'(ny * BOARD_DIM + nx);
                    if (map[nidx]) begin
                        n = n + CNT_W'(1);
                    end
                end
            end
        end
        return n;
    endfunction

    mine_lfsr #(
        .W            (LFSR_W),
        .TAPS         (LFSR_TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .seed  (seed),
        .en    (state_reg == PLACE),
        .value (lfsr_value)
    );

    // The safe cell consumes one square, so at most 63 mines fit when it is enabled.
    always_comb begin
        if (safe_en) begin
            target_next = (mine_count > 7'd63) ? 7'd63 : mine_count;
        end else begin
            target_next = (mine_count > 7'd64) ? 7'd64 : mine_count;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        place_hit  = 1'b0;
        cand       = lfsr_value[5:0];
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = PLACE;
                end
            end
            PLACE: begin
                if (mines_placed == target_reg) begin
                    state_next = WRITE;
                end else if (!bitmap_reg[cand] &&
                             !(safe_en_reg && cand == safe_idx_reg)) begin
                    place_hit = 1'b1;
                end
            end
            WRITE: begin
                if (idx_reg == 6'd63) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cell_next       = '0;
        cell_next.mine  = bitmap_reg[idx_reg];
        cell_next.count = neighbour_count(bitmap_reg, idx_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bitmap_reg   <= '0;
            target_reg   <= '0;
            safe_en_reg  <= 1'b0;
            safe_idx_reg <= '0;
            idx_reg      <= '0;
            mines_placed <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_en        <= 1'b0;
            wr_x         <= '0;
            wr_y         <= '0;
            wr_data      <= '0;
        end else begin
            state_reg <= state_next;
            wr_en     <= 1'b0;
            done      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bitmap_reg   <= '0;
                        mines_placed <= '0;
                        target_reg   <= target_next;
                        safe_en_reg  <= safe_en;
                        safe_idx_reg <= {safe_y[2:0], safe_x[2:0]};
                        idx_reg      <= '0;
                        busy         <= 1'b1;
                    end
                end
                PLACE: begin
                    if (place_hit) begin
                        bitmap_reg[cand] <= 1'b1;
                        mines_placed     <= mines_placed + 7'd1;
                    end
                end
                WRITE: begin
                    wr_en   <= 1'b1;
                    wr_x    <= {1'b0, idx_reg[2:0]};
                    wr_y    <= {1'b0, idx_reg[5:3]};
                    wr_data <= CELL_W'(cell_next);
                    idx_reg <= idx_reg + 6'd1;
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, safe_x[3], safe_y[3], lfsr_value[LFSR_W-1:6]};

endmodule

// File: tb/tb_mine_board_writer.sv
// Directed bench for mine_board_writer: latency, clamping, safe cell, counts, determinism, reset.
module tb_mine_board_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [6:0] mine_count = 7'd0;
    logic       safe_en = 1'b0;
    logic [3:0] safe_x = 4'd0;
    logic [3:0] safe_y = 4'd0;
    logic       busy, done, wr_en;
    logic [3:0] wr_x, wr_y;
    logic [8:0] wr_data;
    logic [6:0] mines_placed;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] stream [64];
    logic [8:0] saved  [64];
    int n_wr, n_done, first_wr_edge, done_edge, order_err;

    mine_board_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed         (seed),
        .mine_count   (mine_count),
        .safe_en      (safe_en),
        .safe_x       (safe_x),
        .safe_y       (safe_y),
        .busy         (busy),
        .done         (done),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_data      (wr_data),
        .mines_placed (mines_placed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int mine_total();
        int t = 0;
        for (int i = 0; i < 64; i++) t += int'(stream[i][0]);
        return t;
    endfunction

    // Rebuild every cell word from the streamed mine bits and count disagreements.
    function automatic int recount_errors();
        int errs = 0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                int cnt = 0;
                logic [8:0] exp_word;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 8 &&
                            y + dy >= 0 && y + dy < 8)
                            cnt += int'(stream[(y + dy) * 8 + x + dx][0]);
                exp_word = {4'b0000, 4'(cnt), stream[y * 8 + x][0]};
                if (stream[y * 8 + x] !== exp_word) errs++;
            end
        end
        return errs;
    endfunction

    function automatic int diff_saved();
        int d = 0;
        for (int i = 0; i < 64; i++) if (stream[i] !== saved[i]) d++;
        return d;
    endfunction

    task automatic save_stream();
        for (int i = 0; i < 64; i++) saved[i] = stream[i];
    endtask

    // Edge numbering: the edge that accepts start is edge 0; sampling is on the falling edge.
    task automatic run_board(input logic [7:0] s, input logic [6:0] mc, input logic se,
                             input logic [3:0] sx, input logic [3:0] sy,
                             input int inject_at, input int reset_at);
        for (int i = 0; i < 64; i++) stream[i] = 9'h1FF;
        n_wr = 0; n_done = 0; first_wr_edge = -1; done_edge = -1; order_err = 0;
        @(negedge clk);
        seed = s; mine_count = mc; safe_en = se; safe_x = sx; safe_y = sy; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 700; e++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr_en) begin
                if (first_wr_edge < 0) first_wr_edge = e;
                if (int'(wr_x) != n_wr % 8 || int'(wr_y) != n_wr / 8) order_err++;
                stream[{wr_y[2:0], wr_x[2:0]}] = wr_data;
                n_wr++;
                if (inject_at >= 0 && n_wr == inject_at) start = 1'b1;
            end
            if (done) begin
                n_done++;
                if (done_edge < 0) done_edge = e;
            end
            if (reset_at >= 0 && n_wr == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_wr_en", wr_en, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                break;
            end
            if (done_edge >= 0 && e >= done_edge + 3) break;
        end
        if (reset_at < 0) check("done_seen", done_edge >= 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_wr_x", wr_x, 0);
        check("reset_wr_y", wr_y, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_mines_placed", mines_placed, 0);
        rst_n = 1'b1;

        // Empty board: one PLACE cycle, writes on edges 2..65, done on edge 66.
        run_board(8'h00, 7'd0, 1'b0, 4'd0, 4'd0, -1, -1);
        check("empty_first_write_edge", first_wr_edge, 2);
        check("empty_done_edge", done_edge, 66);
        check("empty_writes", n_wr, 64);
        check("empty_done_pulses", n_done, 1);
        check("empty_order", order_err, 0);
        check("empty_mines_placed", mines_placed, 0);
        check("empty_mines", mine_total(), 0);
        check("empty_recount", recount_errors(), 0);
        check("empty_idle_busy", busy, 0);

        // Full board.
        run_board(8'h5A, 7'd64, 1'b0, 4'd0, 4'd0, -1, -1);
        check("full_corner_00", stream[0], 9'h007);
        check("full_edge_30", stream[3], 9'h00B);
        check("full_interior_33", stream[27], 9'h011);
        check("full_mines_placed", mines_placed, 64);
        check("full_writes", n_wr, 64);

        // Clamp to 63 with safe cell (3,4); bit 3 of safe_x must be ignored.
        run_board(8'h11, 7'd100, 1'b1, 4'hB, 4'd4, -1, -1);
        check("safe_cell_word", stream[35], 9'h010);
        check("safe_mine_total", mine_total(), 63);
        check("safe_mines_placed", mines_placed, 63);
        check("safe_recount", recount_errors(), 0);

        // Determinism and recount with a sparse board.
        run_board(8'h3C, 7'd10, 1'b0, 4'd0, 4'd0, -1, -1);
        check("s3c_mines", mine_total(), 10);
        check("s3c_recount", recount_errors(), 0);
        check("s3c_mines_placed", mines_placed, 10);
        check("s3c_order", order_err, 0);
        save_stream();
        run_board(8'h3C, 7'd10, 1'b0, 4'd0, 4'd0, -1, -1);
        check("s3c_repeat_diff", diff_saved(), 0);
        run_board(8'h00, 7'd10, 1'b0, 4'd0, 4'd0, -1, -1);
        check("s00_mines", mine_total(), 10);
        check("s00_recount", recount_errors(), 0);
        save_stream();
        run_board(8'hA5, 7'd10, 1'b0, 4'd0, 4'd0, -1, -1);
        check("s00_vs_sa5_diff", diff_saved(), 0);

        // Start pulsed during WRITE must be ignored.
        run_board(8'h3C, 7'd10, 1'b0, 4'd0, 4'd0, 5, -1);
        check("inject_writes", n_wr, 64);
        check("inject_done_pulses", n_done, 1);
        check("inject_order", order_err, 0);
        check("inject_idle_busy", busy, 0);

        // Asynchronous reset after write #20, then a complete fresh board.
        run_board(8'h77, 7'd12, 1'b0, 4'd0, 4'd0, -1, 20);
        check("reset_mid_writes", n_wr, 20);
        repeat (3) @(negedge clk);
        check("reset_hold_wr_en", wr_en, 0);
        check("reset_hold_mines_placed", mines_placed, 0);
        rst_n = 1'b1;
        run_board(8'h42, 7'd5, 1'b0, 4'd0, 4'd0, -1, -1);
        check("after_reset_writes", n_wr, 64);
        check("after_reset_done_pulses", n_done, 1);
        check("after_reset_mines", mine_total(), 5);
        check("after_reset_recount", recount_errors(), 0);
        check("after_reset_mines_placed", mines_placed, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mine_board_writer.md
Name: mine_board_writer

Overview:
- Generates a fresh minesweeper board and writes it, one cell per cycle, into the 8x8 board matrix.
- The matrix is read by the per-coordinate bomb-check logic; this block is the writer side of that matrix.
- Places a requested number of mines pseudo-randomly, with an optional first-click safe cell.
- Then computes each cell's neighbour-mine count and streams all 64 cells out on a write port.

Parameters:
- CELL_W, 9: cell word width.
- LFSR_W, 8: random generator width. Fixed Galois taps x^8+x^6+x^5+x^4+1.
- DEFAULT_SEED, 8'hA5: seed substituted when `seed` is 0.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: request a new board. Sampled only in IDLE.
- seed, in, 8: LFSR seed, captured on an accepted start.
- mine_count, in, 7: requested mines, captured on an accepted start.
- safe_en, in, 1: enables the safe cell, captured on an accepted start.
- safe_x, in, 4: safe cell column, captured on an accepted start. Bit 3 ignored.
- safe_y, in, 4: safe cell row, captured on an accepted start. Bit 3 ignored.
- busy, out, 1: high from the cycle after an accepted start through the last write.
- done, out, 1: one-cycle pulse after the last write.
- wr_en, out, 1: cell write strobe.
- wr_x, out, 4: cell column, bit 3 always 0.
- wr_y, out, 4: cell row, bit 3 always 0.
- wr_data, out, 9: cell word.
- mines_placed, out, 7: mines actually placed. Holds its value until the next start.

Behaviour:
- Cell encoding: [0] mine, [4:1] neighbour count 0..8 (mine cells still carry their count), [8:5] written as 0 (reveal/flag bits owned by game logic).
- Cell index = {y[2:0], x[2:0]}. Neighbours are the 8-connected cells inside the board; no wrap-around.
- Reset values: busy=0, done=0, wr_en=0, wr_x=0, wr_y=0, wr_data=0, mines_placed=0, FSM=IDLE, internal 64-bit mine bitmap=0, lfsr=DEFAULT_SEED.
- Reset takes effect immediately at any point, including mid-PLACE or mid-WRITE. No further writes occur until a new start.
- IDLE: on start=1, go to PLACE and in that same edge:
  - clear the bitmap and placed counter;
  - load lfsr with seed, or DEFAULT_SEED if seed==0;
  - capture the inputs.
- Target: target = min(mine_count, safe_en ? 63 : 64).
- PLACE, one candidate per cycle:
  - If placed==target, go to WRITE and do nothing else.
  - Otherwise cand = lfsr[5:0].
  - If bitmap[cand]==0 and not (safe_en && cand=={safe_y[2:0],safe_x[2:0]}), set the bit and increment placed.
  - lfsr advances every PLACE cycle.
  - Every 6-bit value recurs within the 255-cycle period, so PLACE always terminates.
- WRITE: 64 cycles, x fastest: (0,0),(1,0)..(7,0),(0,1)..(7,7).
  - wr_en=1 each cycle; outputs are registered.
  - wr_data is computed combinationally from the bitmap for the current index, then registered with it.
  - After the (7,7) write, go to DONE.
- DONE: done=1, busy=0, wr_en=0 for one cycle, then IDLE.
- start while busy or in DONE is ignored.
- Latency: start accepted at edge 0 → P PLACE cycles (P ≥ target+1) → writes at edges P+1..P+64 → done at edge P+65.
- mines_placed updates live during PLACE and equals target at done.
- Determinism: identical seed and inputs give an identical write stream. seed 0 and seed 8'hA5 give identical streams.

Decomposition:
- Package minesweeper_pkg holds:
  - BOARD_DIM=8, CELL_W=9;
  - cell field positions (MINE_BIT=0, CNT_LSB=1, CNT_W=4);
  - the cell_t typedef;
  - the FSM enum {IDLE, PLACE, WRITE, DONE}.
- Sub-module mine_lfsr: 8-bit Galois LFSR with load and enable inputs.
- Neighbour counting stays as a function inside mine_board_writer.

Test Plan:
- mine_count=0, seed=0, safe_en=0 → 1 PLACE cycle, 64 writes all wr_data=9'h000, done at edge 66, mines_placed=0.
- mine_count=64, safe_en=0 → every cell is a mine:
  - corner (0,0) wr_data=9'h007;
  - edge (3,0) wr_data=9'h00B;
  - interior (3,3) wr_data=9'h011;
  - mines_placed=64.
- mine_count=100, safe_en=1, safe=(3,4) → clamped to 63; cell (3,4) wr_data=9'h010; all other cells have bit0=1; mines_placed=63.
- mine_count=10, seed=8'h3C, run twice; then seed 0 vs seed 8'hA5:
  - the two 8'h3C runs give identical 64-word streams;
  - seed 0 and seed 8'hA5 give identical streams;
  - exactly 10 cells have bit0=1;
  - every count equals a scoreboard recount.
- Pulse start again during WRITE → ignored: exactly 64 writes and a single done pulse.
- Assert rst_n=0 at write #20 → wr_en, busy and done are 0 immediately. After release, a new start produces a complete 64-write board.
